// File: rtl/img_pkg.sv
// Shared types and defaults for the pixel-to-AXI-stream packing path.
package img_pkg;

    localparam int unsigned PIXEL_W      = 8;
    localparam int unsigned PIX_PER_WORD = 4;
    localparam int unsigned LINE_PIXELS  = 512;
    localparam int unsigned FRAME_LINES  = 512;

    function automatic int unsigned word_w(input int unsigned ppw);
        return PIXEL_W * ppw;
    endfunction

    localparam int unsigned WORD_W = word_w(PIX_PER_WORD);

    // One packed output word plus its sideband, as held in the output FIFO.
    // frame_end tags the word that closes the frame so the interrupt can
    // follow the word out rather than fire when it is merely queued.
    typedef struct packed {
        logic              frame_end;
        logic              user;
        logic              last;
        logic [WORD_W-1:0] data;
    } word_entry_t;

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Pixel input and packed-word output handshake bundle for the packer.
interface pixel_stream_packer_if #(
    parameter int unsigned PIXEL_W      = img_pkg::PIXEL_W,
    parameter int unsigned PIX_PER_WORD = img_pkg::PIX_PER_WORD
);
    logic                              i_data_valid;
    logic [PIXEL_W-1:0]                i_data;
    logic                              o_data_ready;
    logic                              o_data_valid;
    logic [PIXEL_W*PIX_PER_WORD-1:0]   o_data;
    logic                              o_data_last;
    logic                              o_data_user;
    logic                              i_data_ready;
    logic                              o_intr;

    // Packer side.
    modport slave (
        input  i_data_valid, i_data, i_data_ready,
        output o_data_ready, o_data_valid, o_data, o_data_last, o_data_user, o_intr
    );

    // Environment side: pixel source and DMA sink.
    modport master (
        output i_data_valid, i_data, i_data_ready,
        input  o_data_ready, o_data_valid, o_data, o_data_last, o_data_user, o_intr
    );
endinterface

// File: rtl/axis_fifo2.sv
// Two-entry FIFO whose head is a flop, so the output is registered.
module axis_fifo2
    import img_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  word_entry_t data_i,
    input  logic        pop_i,
    output word_entry_t data_o,
    output logic        full_o,
    output logic        empty_o
);

    logic [1:0]  cnt_q, cnt_d;
    word_entry_t head_q, head_d;
    word_entry_t tail_q, tail_d;

    // Next-state: head always holds the oldest entry, tail the second one.
    always_comb begin
        cnt_d  = cnt_q;
        head_d = head_q;
        tail_d = tail_q;
        case (cnt_q)
            2'd0: begin
                if (push_i) begin
                    head_d = data_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push_i && pop_i) begin
                    head_d = data_i;
                end else if (push_i) begin
                    tail_d = data_i;
                    cnt_d  = 2'd2;
                end else if (pop_i) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                // Push while full without a pop is never issued by the packer.
                if (pop_i) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = data_i;
                    end else begin
                        cnt_d = 2'd1;
                    end
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign data_o  = head_q;
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/pixel_stream_packer.sv
// Packs the filtered pixel stream into 32-bit AXI-stream words with
// end-of-line (last), start-of-frame (user) and a frame-done interrupt.
module pixel_stream_packer #(
    parameter int unsigned PIXEL_W      = img_pkg::PIXEL_W,
    parameter int unsigned PIX_PER_WORD = img_pkg::PIX_PER_WORD,
    parameter int unsigned LINE_PIXELS  = img_pkg::LINE_PIXELS,
    parameter int unsigned FRAME_LINES  = img_pkg::FRAME_LINES
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset,
    pixel_stream_packer_if.slave  bus
);
    import img_pkg::*;

    localparam int unsigned LaneW = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam int unsigned ColW  = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int unsigned RowW  = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

    localparam logic [LaneW-1:0] LaneLast = LaneW'(PIX_PER_WORD - 1);
    localparam logic [ColW-1:0]  ColLast  = ColW'(LINE_PIXELS - 1);
    localparam logic [RowW-1:0]  RowLast  = RowW'(FRAME_LINES - 1);

    if ((LINE_PIXELS % PIX_PER_WORD) != 0) begin : g_bad_line
        $error("LINE_PIXELS must be a multiple of PIX_PER_WORD");
    end
    if (PIXEL_W * PIX_PER_WORD != WORD_W) begin : g_bad_word
        $error("PIXEL_W*PIX_PER_WORD must match the shared word width");
    end

    logic [LaneW-1:0]  lane_q, lane_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic              first_q, first_d;
    logic              intr_q, intr_d;

    logic        accept;
    logic        push;
    logic        pop;
    logic        word_user;
    logic        fifo_full;
    logic        fifo_empty;
    word_entry_t push_entry;
    word_entry_t head;

    // Stall only when the word being completed would have nowhere to go; this
    // depends on registered state alone, so a same-cycle pop still stalls.
    assign bus.o_data_ready = !(fifo_full && (lane_q == LaneLast));
    assign accept           = bus.i_data_valid && bus.o_data_ready;
    assign pop              = !fifo_empty && bus.i_data_ready;

    // Position counters, little-endian packing and word completion.
    always_comb begin
        lane_d     = lane_q;
        col_d      = col_q;
        row_d      = row_q;
        pack_d     = pack_q;
        first_d    = first_q;
        push       = 1'b0;
        push_entry = '0;
        word_user  = first_q;
        if (accept) begin
            for (int i = 0; i < int'(PIX_PER_WORD); i++) begin
                if (lane_q == LaneW'(i)) begin
                    pack_d[i*PIXEL_W +: PIXEL_W] = bus.i_data;
                end
            end
            if (lane_q == '0) begin
                word_user = (col_q == '0) && (row_q == '0);
                first_d   = word_user;
            end
            if (lane_q == LaneLast) begin
                push                 = 1'b1;
                push_entry.data      = pack_d;
                push_entry.user      = word_user;
                push_entry.last      = (col_q == ColLast);
                push_entry.frame_end = (col_q == ColLast) && (row_q == RowLast);
                lane_d               = '0;
            end else begin
                lane_d = lane_q + 1'b1;
            end
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Interrupt fires the cycle after the frame-closing word is handed off.
    always_comb begin
        intr_d = pop && head.frame_end;
    end

    // State registers; reset drops any partial word and restarts the frame.
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            lane_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pack_q  <= '0;
            first_q <= 1'b0;
            intr_q  <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pack_q  <= pack_d;
            first_q <= first_d;
            intr_q  <= intr_d;
        end
    end

    axis_fifo2 u_fifo (
        .clk_i   (axi_clk),
        .rst_i   (axi_reset),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.o_data_valid = !fifo_empty;
    assign bus.o_data       = head.data;
    assign bus.o_data_last  = head.last;
    assign bus.o_data_user  = head.user;
    assign bus.o_intr       = intr_q;

endmodule
